// File: rtl/divider_8bit_seq.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient
// and remainder. Restoring shift-subtract on magnitudes, one quotient bit per
// cycle, followed by a single sign-fix cycle. Start/busy/done handshake.
module divider_8bit_seq #(
  parameter int W = 8
) (
  input  logic           cclk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] X,
  input  logic [W-1:0]   Y,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   R,
  output logic           dbz,
  output logic           ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = $clog2(2*W);
  // Largest positive quotient magnitude; the negative limit is one more.
  localparam logic [2*W-1:0] QPOS = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] QNEG = QPOS + 1'b1;

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  dvd;     // dividend magnitude, consumed MSB first
  logic [2*W-1:0]  qmag;    // quotient magnitude, built LSB in
  logic [W:0]      rem;     // partial remainder, one guard bit for the shift
  logic [W-1:0]    ymag;
  logic            sign_q, sign_r;

  // Operand magnitudes kept unsigned so the most-negative values survive.
  logic [2*W-1:0]  xabs;
  logic [W-1:0]    yabs;
  assign xabs = X[2*W-1] ? (~X + 1'b1) : X;
  assign yabs = Y[W-1]   ? (~Y + 1'b1) : Y;

  // One restoring step: bring in next dividend bit, trial-subtract divisor.
  logic [W:0]      shifted, diff;
  logic            ge;
  assign shifted = {rem[W-1:0], dvd[2*W-1]};
  assign diff    = shifted - {1'b0, ymag};
  assign ge      = (shifted >= {1'b0, ymag});

  // Signed results from the finished magnitudes.
  logic [W-1:0]    qlo, rlo;
  logic            ovf_c;
  assign qlo   = qmag[W-1:0];
  assign rlo   = rem[W-1:0];
  assign ovf_c = sign_q ? (qmag > QNEG) : (qmag > QPOS);

  // State register.
  always_ff @(posedge cclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state decode; busy covers every non-idle cycle.
  always_comb begin
    nxt  = state;
    busy = 1'b0;
    case (state)
      IDLE: if (start) nxt = (Y == '0) ? FIX : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) nxt = FIX;
      end
      FIX: begin
        busy = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operand capture, shift-subtract iterations, result write-back.
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      cnt    <= '0;
      dvd    <= '0;
      qmag   <= '0;
      rem    <= '0;
      ymag   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      done   <= 1'b0;
      Q      <= '0;
      R      <= '0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvd    <= xabs;
          ymag   <= yabs;
          sign_q <= X[2*W-1] ^ Y[W-1];
          sign_r <= X[2*W-1];
          qmag   <= '0;
          rem    <= '0;
          cnt    <= CW'(2*W-1);
        end
        CALC: begin
          dvd  <= {dvd[2*W-2:0], 1'b0};
          qmag <= {qmag[2*W-2:0], ge};
          rem  <= ge ? diff : shifted;
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (ymag == '0) begin
            Q   <= '0;
            R   <= '0;
            dbz <= 1'b1;
            ovf <= 1'b0;
          end else begin
            Q   <= sign_q ? (~qlo + 1'b1) : qlo;
            R   <= sign_r ? (~rlo + 1'b1) : rlo;
            dbz <= 1'b0;
            ovf <= ovf_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_8bit_seq.sv
// Bench for divider_8bit_seq: directed corner cases plus a randomized sweep of
// every divisor, checked against integer division in a reference model.
module tb_divider_8bit_seq;

  logic        cclk = 1'b0;
  logic        rst_n, start;
  logic [15:0] X;
  logic [7:0]  Y;
  logic        busy, done, dbz, ovf;
  logic [7:0]  Q, R;

  int nchk = 0;
  int nerr = 0;

  divider_8bit_seq #(.W(8)) dut (
    .cclk(cclk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .Q(Q), .R(R), .dbz(dbz), .ovf(ovf)
  );

  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: truncating signed integer division.
  task automatic model(input logic [15:0] x, input logic [7:0] y,
                       output logic [7:0] eq, output logic [7:0] er,
                       output logic edbz, output logic eovf);
    int xi, yi, qi, ri;
    xi = int'($signed(x));
    yi = int'($signed(y));
    if (yi == 0) begin
      eq = 8'h00; er = 8'h00; edbz = 1'b1; eovf = 1'b0;
    end else begin
      qi = xi / yi;
      ri = xi % yi;
      eq = qi[7:0];
      er = ri[7:0];
      edbz = 1'b0;
      eovf = (qi > 127) || (qi < -128);
    end
  endtask

  // Caller is #1 after an edge (cycle N); returns #1 into cycle N+1.
  task automatic launch(input logic [15:0] x, input logic [7:0] y);
    start = 1'b1; X = x; Y = y;
    @(posedge cclk); #1;
    start = 1'b0;
    X = $urandom; Y = $urandom;   // operands must already be captured
    chk("busy_n1", busy, 1'b1);
  endtask

  // Wait for done counting cycles after N, then check latency and results.
  task automatic finish_check(input logic [15:0] x, input logic [7:0] y, input int cyc0);
    logic [7:0] eq, er;
    logic edbz, eovf;
    int cyc;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge cclk); #1;
      cyc++;
    end
    model(x, y, eq, er, edbz, eovf);
    chk("latency", cyc, (y == 8'h00) ? 2 : 18);
    chk("q",   Q,   eq);
    chk("r",   R,   er);
    chk("dbz", dbz, edbz);
    chk("ovf", ovf, eovf);
  endtask

  task automatic run_div(input logic [15:0] x, input logic [7:0] y);
    @(posedge cclk); #1;
    launch(x, y);
    finish_check(x, y, 1);
  endtask

  initial begin
    logic        seen;
    logic [7:0]  yb, kb;
    int          yi, k, ay, r, p;
    logic [15:0] xb;

    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0;
    repeat (3) @(posedge cclk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q",    Q,    8'h00);
    chk("rst_r",    R,    8'h00);
    chk("rst_dbz",  dbz,  1'b0);
    chk("rst_ovf",  ovf,  1'b0);
    rst_n = 1'b1;

    // Directed cases with literal expectations anchoring the model.
    run_div(16'h0064, 8'h07);
    chk("c1_q", Q, 8'h0E); chk("c1_r", R, 8'h02);
    run_div(16'hFF9C, 8'h07);
    chk("c2_q", Q, 8'hF2); chk("c2_r", R, 8'hFE);
    run_div(16'h4000, 8'h80);
    chk("c3a_q", Q, 8'h80); chk("c3a_ovf", ovf, 1'b0);
    run_div(16'hC000, 8'h80);
    chk("c3b_q", Q, 8'h80); chk("c3b_ovf", ovf, 1'b1);
    run_div(16'h1234, 8'h00);
    chk("c4_dbz", dbz, 1'b1);
    run_div(16'h8000, 8'hFF);
    run_div(16'h8000, 8'h80);
    run_div(16'h8000, 8'h01);
    run_div(16'h7FFF, 8'h7F);
    run_div(16'h0000, 8'h80);

    // Start pulse mid-division is ignored; start in done cycle is accepted.
    @(posedge cclk); #1;
    launch(16'h0064, 8'h07);
    repeat (4) begin @(posedge cclk); #1; end   // now in N+5
    start = 1'b1; X = 16'h0001; Y = 8'h01;
    @(posedge cclk); #1;
    start = 1'b0;
    finish_check(16'h0064, 8'h07, 6);
    launch(16'hFF9C, 8'h07);
    finish_check(16'hFF9C, 8'h07, 1);
    launch(16'h1234, 8'h00);
    finish_check(16'h1234, 8'h00, 1);
    launch(16'h0064, 8'h07);
    finish_check(16'h0064, 8'h07, 1);

    // Reset at N+7 aborts the division with no done pulse.
    @(posedge cclk); #1;
    launch(16'h7000, 8'h03);
    repeat (6) begin @(posedge cclk); #1; end   // now in N+7
    rst_n = 1'b0;
    @(posedge cclk); #1;
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_q",    Q,    8'h00);
    chk("abort_r",    R,    8'h00);
    seen = done;
    repeat (30) begin @(posedge cclk); #1; seen |= done; end
    chk("abort_nodone", seen, 1'b0);

    // Every divisor, dividends formed as Y*k + r with |r| < |Y|.
    for (int rep = 0; rep < 3; rep++) begin
      for (int yv = 0; yv < 256; yv++) begin
        yb = 8'(yv);
        yi = int'($signed(yb));
        kb = 8'($urandom);
        k  = int'($signed(kb));
        ay = (yi < 0) ? -yi : yi;
        r  = (ay > 0) ? int'($urandom_range(ay - 1, 0)) : 0;
        p  = yi * k;
        if (p < 0) r = -r;
        xb = (yi == 0) ? 16'($urandom) : 16'(p + r);
        run_div(xb, yb);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
